// File: rtl/set_assoc_kv_store.sv
// Set-associative key/value store: combinational lookup, 1-cycle update/invalidate, round-robin replacement, 2**SET_WIDTH-cycle flush.
// No backpressure: every request is accepted in the cycle it is presented; updates and invalidates are silently ignored while flush_busy is high.
module set_assoc_kv_store #(
  parameter int KEY_WIDTH = 32,
  parameter int VAL_WIDTH = 32,
  parameter int SET_WIDTH = 4,
  parameter int WAY_NUM   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 hit,
  output logic [VAL_WIDTH-1:0] value,
  input  logic                 update_valid,
  input  logic [KEY_WIDTH-1:0] update_key,
  input  logic [VAL_WIDTH-1:0] update_value,
  input  logic                 inval_valid,
  input  logic [KEY_WIDTH-1:0] inval_key,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 evict_valid,
  output logic [KEY_WIDTH-1:0] evict_key,
  output logic [VAL_WIDTH-1:0] evict_value
);
  localparam int SETS = 1 << SET_WIDTH;
  localparam int WIDX = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  if (SET_WIDTH > KEY_WIDTH || KEY_WIDTH == 0 || VAL_WIDTH == 0 || SET_WIDTH == 0 ||
      WAY_NUM < 1 || WAY_NUM > 8) begin : g_bad_param
    $fatal(1, "set_assoc_kv_store: illegal parameter combination");
  end

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               r_state;
  logic [SET_WIDTH-1:0] r_cnt;
  logic [WAY_NUM-1:0]   r_valid [SETS];
  logic [WIDX-1:0]      r_rr    [SETS];
  logic [KEY_WIDTH-1:0] r_key   [SETS][WAY_NUM];
  logic [VAL_WIDTH-1:0] r_val   [SETS][WAY_NUM];
  logic                 r_evict_vld;
  logic [KEY_WIDTH-1:0] r_evict_key;
  logic [VAL_WIDTH-1:0] r_evict_val;

  logic [SET_WIDTH-1:0] w_lk_set, w_up_set, w_iv_set;
  logic                 w_lk_hit;
  logic [VAL_WIDTH-1:0] w_lk_val;
  logic                 w_up_match, w_up_free, w_iv_match;
  logic [WIDX-1:0]      w_up_match_way, w_up_free_way, w_up_way, w_iv_way;
  logic                 w_idle, w_replace, w_do_update, w_do_inval;

  assign w_lk_set = key[SET_WIDTH-1:0];
  assign w_up_set = update_key[SET_WIDTH-1:0];
  assign w_iv_set = inval_key[SET_WIDTH-1:0];
  assign w_idle   = (r_state == IDLE);

  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_val = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (r_valid[w_lk_set][i] && r_key[w_lk_set][i] == key) begin
        w_lk_hit = 1'b1;
        w_lk_val = r_val[w_lk_set][i];
      end
    end
  end

  assign hit        = w_lk_hit && w_idle;
  assign value      = hit ? w_lk_val : '0;
  assign flush_busy = !w_idle;

  // Placement priority: in-place overwrite, then lowest free way, then round-robin victim.
  always_comb begin
    w_up_match     = 1'b0;
    w_up_match_way = '0;
    w_up_free      = 1'b0;
    w_up_free_way  = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (r_valid[w_up_set][i] && r_key[w_up_set][i] == update_key) begin
        w_up_match     = 1'b1;
        w_up_match_way = WIDX'(i);
      end
      if (!r_valid[w_up_set][i] && !w_up_free) begin
        w_up_free     = 1'b1;
        w_up_free_way = WIDX'(i);
      end
    end
  end

  always_comb begin
    w_iv_match = 1'b0;
    w_iv_way   = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (r_valid[w_iv_set][i] && r_key[w_iv_set][i] == inval_key) begin
        w_iv_match = 1'b1;
        w_iv_way   = WIDX'(i);
      end
    end
  end

  assign w_up_way    = w_up_match ? w_up_match_way : (w_up_free ? w_up_free_way : r_rr[w_up_set]);
  assign w_replace   = !w_up_match && !w_up_free;
  assign w_do_inval  = w_idle && inval_valid && w_iv_match;
  assign w_do_update = w_idle && update_valid && !inval_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_evict_vld <= 1'b0;
    end else begin
      r_evict_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_do_inval)
            r_valid[w_iv_set][w_iv_way] <= 1'b0;
          if (w_do_update) begin
            r_valid[w_up_set][w_up_way] <= 1'b1;
            if (w_replace) begin
              r_evict_vld    <= 1'b1;
              r_rr[w_up_set] <= (r_rr[w_up_set] == WIDX'(WAY_NUM - 1)) ? '0 : r_rr[w_up_set] + 1'b1;
            end
          end
          if (flush_req) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end
        end
        FLUSH: begin
          r_valid[r_cnt] <= '0;
          r_rr[r_cnt]    <= '0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == SET_WIDTH'(SETS - 1))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Payload arrays carry no reset; only the valid bits decide visibility.
  always_ff @(posedge clk) begin
    if (reset && w_do_update) begin
      r_key[w_up_set][w_up_way] <= update_key;
      r_val[w_up_set][w_up_way] <= update_value;
      if (w_replace) begin
        r_evict_key <= r_key[w_up_set][w_up_way];
        r_evict_val <= r_val[w_up_set][w_up_way];
      end
    end
  end

  assign evict_valid = r_evict_vld;
  assign evict_key   = r_evict_key;
  assign evict_value = r_evict_val;

endmodule

// File: tb/tb_set_assoc_kv_store.sv
// Bench for set_assoc_kv_store (8-bit keys/values, 4 sets, 2 ways): directed scenarios plus
// randomized traffic compared against a per-set replacement model held in the bench.
module tb_set_assoc_kv_store;
  localparam int KW = 8, VW = 8, SW = 2, WN = 2, NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KW-1:0] key;
  logic          hit;
  logic [VW-1:0] value;
  logic          update_valid;
  logic [KW-1:0] update_key;
  logic [VW-1:0] update_value;
  logic          inval_valid;
  logic [KW-1:0] inval_key;
  logic          flush_req;
  logic          flush_busy;
  logic          evict_valid;
  logic [KW-1:0] evict_key;
  logic [VW-1:0] evict_value;

  int checks = 0;
  int errors = 0;

  // Reference model: contents per set/way, replacement pointer, remaining flush cycles.
  bit            m_v  [NS][WN];
  logic [KW-1:0] m_k  [NS][WN];
  logic [VW-1:0] m_d  [NS][WN];
  int            m_rr [NS];
  int            m_busy;
  bit            m_ev;
  logic [KW-1:0] m_evk;
  logic [VW-1:0] m_evd;

  set_assoc_kv_store #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .SET_WIDTH(SW), .WAY_NUM(WN)) dut (
    .clk(clk), .reset(rst_n), .key(key), .hit(hit), .value(value),
    .update_valid(update_valid), .update_key(update_key), .update_value(update_value),
    .inval_valid(inval_valid), .inval_key(inval_key), .flush_req(flush_req),
    .flush_busy(flush_busy), .evict_valid(evict_valid), .evict_key(evict_key),
    .evict_value(evict_value)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WN; w++) m_v[s][w] = 0;
    end
  endtask

  task automatic model_lookup(input logic [KW-1:0] k, output bit h, output logic [VW-1:0] v);
    int s;
    s = int'(k) % NS;
    h = 0;
    v = '0;
    if (m_busy == 0)
      for (int w = 0; w < WN; w++)
        if (m_v[s][w] && m_k[s][w] == k) begin h = 1; v = m_d[s][w]; end
  endtask

  // Applies the request visible at a clock edge to the model.
  task automatic model_step();
    int s, w;
    m_ev = 0;
    if (!rst_n) begin
      model_clear();
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (inval_valid) begin
        s = int'(inval_key) % NS;
        for (int i = 0; i < WN; i++)
          if (m_v[s][i] && m_k[s][i] == inval_key) m_v[s][i] = 0;
      end else if (update_valid) begin
        s = int'(update_key) % NS;
        w = -1;
        for (int i = 0; i < WN; i++)
          if (m_v[s][i] && m_k[s][i] == update_key) w = i;
        if (w < 0)
          for (int i = 0; i < WN; i++)
            if (!m_v[s][i] && w < 0) w = i;
        if (w < 0) begin
          w = m_rr[s];
          m_ev = 1; m_evk = m_k[s][w]; m_evd = m_d[s][w];
          m_rr[s] = (m_rr[s] + 1) % WN;
        end
        m_v[s][w] = 1; m_k[s][w] = update_key; m_d[s][w] = update_value;
      end
      if (flush_req) begin
        model_clear();
        m_busy = NS;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    update_valid = 0; inval_valid = 0; flush_req = 0;
  endtask

  task automatic do_update(input logic [KW-1:0] k, input logic [VW-1:0] v);
    update_valid = 1; update_key = k; update_value = v;
    step();
    update_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); key = 8'h15;
    update_key = '0; update_value = '0; inval_key = '0;
    step(); step();
    rst_n = 1;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", hit); end
    checks++; if (value !== 8'h00) begin errors++; $display("FAIL reset_value got %h want 00", value); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", flush_busy); end
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL reset_evict got %b want 0", evict_valid); end
  endtask

  task automatic test_update_visibility();
    update_valid = 1; update_key = 8'h05; update_value = 8'hAA; key = 8'h05;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit got %b want 0", hit); end
    step();
    update_valid = 0;
    #1;
    checks++; if (hit !== 1'b1 || value !== 8'hAA)
      begin errors++; $display("FAIL next_cycle_hit got %b/%h want 1/aa", hit, value); end
    key = 8'h09; #1;
    checks++; if (hit !== 1'b0 || value !== 8'h00)
      begin errors++; $display("FAIL other_key_miss got %b/%h want 0/00", hit, value); end
  endtask

  task automatic test_evict();
    do_update(8'h05, 8'h11);
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL overwrite_no_evict got %b want 0", evict_valid); end
    do_update(8'h09, 8'h22);
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL fill_no_evict got %b want 0", evict_valid); end
    do_update(8'h0D, 8'h33);
    checks++; if (evict_valid !== 1'b1 || evict_key !== 8'h05 || evict_value !== 8'h11)
      begin errors++; $display("FAIL evict_report got %b/%h/%h want 1/05/11", evict_valid, evict_key, evict_value); end
    step();
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL evict_one_cycle got %b want 0", evict_valid); end
    key = 8'h05; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evicted_miss got %b want 0", hit); end
    key = 8'h09; #1;
    checks++; if (hit !== 1'b1 || value !== 8'h22) begin errors++; $display("FAIL kept_09 got %b/%h want 1/22", hit, value); end
    key = 8'h0D; #1;
    checks++; if (hit !== 1'b1 || value !== 8'h33) begin errors++; $display("FAIL new_0d got %b/%h want 1/33", hit, value); end
  endtask

  task automatic test_overwrite_inval();
    do_update(8'h09, 8'h44);
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL inplace_no_evict got %b want 0", evict_valid); end
    key = 8'h09; #1;
    checks++; if (hit !== 1'b1 || value !== 8'h44) begin errors++; $display("FAIL inplace_value got %b/%h want 1/44", hit, value); end
    inval_valid = 1; inval_key = 8'h09;
    update_valid = 1; update_key = 8'h09; update_value = 8'h55;
    step();
    idle_inputs();
    #1;
    checks++; if (hit !== 1'b0 || evict_valid !== 1'b0)
      begin errors++; $display("FAIL inval_wins got hit %b evict %b want 0/0", hit, evict_valid); end
  endtask

  task automatic test_flush();
    int n;
    key = 8'h0D; flush_req = 1;
    step();
    flush_req = 0;
    n = 0;
    while (flush_busy === 1'b1 && n < 20) begin
      update_valid = (n == 1); update_key = 8'h01; update_value = 8'h77;
      flush_req = (n == 2);
      #1;
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_hit cycle %0d got %b want 0", n, hit); end
      step();
      n++;
    end
    idle_inputs();
    checks++; if (n != NS) begin errors++; $display("FAIL flush_length got %0d want %0d", n, NS); end
    key = 8'h01; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_update_ignored got %b want 0", hit); end
    key = 8'h0D; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_cleared got %b want 0", hit); end
  endtask

  task automatic test_reset_mid_flush();
    do_update(8'h02, 8'h12);
    flush_req = 1;
    step();
    flush_req = 0;
    checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL midflush_busy got %b want 1", flush_busy); end
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    key = 8'h02; #1;
    checks++; if (flush_busy !== 1'b0 || hit !== 1'b0 || evict_valid !== 1'b0)
      begin errors++; $display("FAIL midflush_reset got busy %b hit %b evict %b want 0/0/0", flush_busy, hit, evict_valid); end
    do_update(8'h01, 8'h99);
    key = 8'h01; #1;
    checks++; if (evict_valid !== 1'b0 || hit !== 1'b1 || value !== 8'h99)
      begin errors++; $display("FAIL post_reset_fill got evict %b hit %b val %h want 0/1/99", evict_valid, hit, value); end
    do_update(8'h05, 8'h5A);
    do_update(8'h09, 8'h9A);
    checks++; if (evict_valid !== 1'b1 || evict_key !== 8'h01 || evict_value !== 8'h99)
      begin errors++; $display("FAIL post_reset_way0 got %b/%h/%h want 1/01/99", evict_valid, evict_key, evict_value); end
  endtask

  task automatic test_random();
    bit            eh;
    logic [VW-1:0] ev;
    for (int it = 0; it < 400; it++) begin
      key          = 8'($urandom_range(0, 15));
      update_valid = ($urandom_range(0, 99) < 50);
      update_key   = 8'($urandom_range(0, 15));
      update_value = 8'($urandom);
      inval_valid  = ($urandom_range(0, 99) < 15);
      inval_key    = 8'($urandom_range(0, 15));
      flush_req    = ($urandom_range(0, 99) < 3);
      rst_n        = ($urandom_range(0, 99) >= 2);
      #1;
      model_lookup(key, eh, ev);
      checks++; if (hit !== eh || value !== ev)
        begin errors++; $display("FAIL rand_lookup it %0d key %h got %b/%h want %b/%h", it, key, hit, value, eh, ev); end
      step();
      checks++; if (flush_busy !== (m_busy > 0))
        begin errors++; $display("FAIL rand_busy it %0d got %b want %b", it, flush_busy, m_busy > 0); end
      checks++; if (evict_valid !== m_ev || (m_ev && (evict_key !== m_evk || evict_value !== m_evd)))
        begin errors++; $display("FAIL rand_evict it %0d got %b/%h/%h want %b/%h/%h", it, evict_valid, evict_key, evict_value, m_ev, m_evk, m_evd); end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    m_busy = 0; m_ev = 0;
    model_clear();
    test_reset();
    test_update_visibility();
    test_evict();
    test_overwrite_inval();
    test_flush();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
